// File: rtl/res_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// res_port_arbiter_if
// Purpose : One requester port of the result-RAM arbiter. A requester asserts
//           req with we/lock/addr/wdata held stable until it sees gnt. Read
//           data comes back one cycle after the grant, qualified by rvalid.
// Signals : req    request an access this cycle
//           we     1 = write, 0 = read
//           lock   keep ownership while req stays high (burst)
//           addr   RAM address
//           wdata  write data
//           gnt    access issued to the RAM this cycle
//           rvalid read data valid on rdata
//           rdata  read data (0 when rvalid is low)
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface res_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/res_port_arbiter.sv
// -----------------------------------------------------------------------------
// res_port_arbiter
// Purpose : Shares the single-port result RAM (1-cycle synchronous read)
//           between port A (distance-transform engine) and port B (host).
//           One access per cycle, round-robin with a bounded hold and a burst
//           lock. The grant and the RAM command are combinational from the
//           current requests and the registered arbitration state.
// Ports   : i_clk       clock, all state on the rising edge
//           i_rst       asynchronous active-high reset
//           io_a, io_b  requester ports (res_port_arbiter_if.slave)
//           o_res_rd    RAM read strobe
//           o_res_wr    RAM write strobe
//           o_res_addr  RAM address
//           o_res_do    RAM write data
//           i_res_di    RAM read data, valid the cycle after o_res_rd
// -----------------------------------------------------------------------------
module res_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    res_port_arbiter_if.slave   io_a,
    res_port_arbiter_if.slave   io_b,
    output logic                o_res_rd,
    output logic                o_res_wr,
    output logic [ADDR_W-1:0]   o_res_addr,
    output logic [DATA_W-1:0]   o_res_do,
    input  logic [DATA_W-1:0]   i_res_di
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_last_b;        // 1: last grant went to B (A wins next tie)
    logic             w_last_b_next;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_next;
    logic [CNT_W-1:0] w_hold_inc;
    logic             r_rd_pend_a;
    logic             r_rd_pend_b;
    logic             w_gnt_a;
    logic             w_gnt_b;

    // Next-state, grant and RAM command decode.
    always_comb begin
        w_gnt_a       = 1'b0;
        w_gnt_b       = 1'b0;
        w_state_next  = ST_IDLE;
        w_last_b_next = r_last_b;
        w_hold_next   = '0;
        w_hold_inc    = (r_hold_cnt == HOLD_MAX) ? HOLD_MAX : r_hold_cnt + CNT_W'(1);

        // Grants are suppressed while reset is held so the RAM sees no command.
        if (!i_rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (io_a.req && io_b.req) begin
                        w_gnt_a = r_last_b;
                        w_gnt_b = ~r_last_b;
                    end else begin
                        w_gnt_a = io_a.req;
                        w_gnt_b = io_b.req;
                    end
                end
                ST_OWN_A: begin
                    // Failing the keep condition with A requesting implies B requests.
                    if (io_a.req && (io_a.lock || !io_b.req || r_hold_cnt < HOLD_MAX))
                        w_gnt_a = 1'b1;
                    else
                        w_gnt_b = io_b.req;
                end
                ST_OWN_B: begin
                    if (io_b.req && (io_b.lock || !io_a.req || r_hold_cnt < HOLD_MAX))
                        w_gnt_b = 1'b1;
                    else
                        w_gnt_a = io_a.req;
                end
                default: begin
                    w_gnt_a = 1'b0;
                    w_gnt_b = 1'b0;
                end
            endcase
        end

        if (w_gnt_a) begin
            w_state_next  = ST_OWN_A;
            w_last_b_next = 1'b0;
            w_hold_next   = (r_state == ST_OWN_A) ? w_hold_inc : CNT_W'(1);
        end else if (w_gnt_b) begin
            w_state_next  = ST_OWN_B;
            w_last_b_next = 1'b1;
            w_hold_next   = (r_state == ST_OWN_B) ? w_hold_inc : CNT_W'(1);
        end
    end

    // Access issued in the grant cycle; all command pins idle at 0 otherwise.
    always_comb begin
        o_res_rd   = (w_gnt_a & ~io_a.we) | (w_gnt_b & ~io_b.we);
        o_res_wr   = (w_gnt_a &  io_a.we) | (w_gnt_b &  io_b.we);
        o_res_addr = '0;
        o_res_do   = '0;
        if (w_gnt_a) begin
            o_res_addr = io_a.addr;
            o_res_do   = io_a.wdata;
        end else if (w_gnt_b) begin
            o_res_addr = io_b.addr;
            o_res_do   = io_b.wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_last_b    <= 1'b1;
            r_hold_cnt  <= '0;
            r_rd_pend_a <= 1'b0;
            r_rd_pend_b <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_last_b    <= w_last_b_next;
            r_hold_cnt  <= w_hold_next;
            r_rd_pend_a <= w_gnt_a & ~io_a.we;
            r_rd_pend_b <= w_gnt_b & ~io_b.we;
        end
    end

    // Only one read is ever pending, so the shared RAM data goes to its owner.
    assign io_a.gnt    = w_gnt_a;
    assign io_b.gnt    = w_gnt_b;
    assign io_a.rvalid = r_rd_pend_a;
    assign io_b.rvalid = r_rd_pend_b;
    assign io_a.rdata  = r_rd_pend_a ? i_res_di : '0;
    assign io_b.rdata  = r_rd_pend_b ? i_res_di : '0;

endmodule

// File: tb/tb_res_port_arbiter.sv
module tb_res_port_arbiter;

    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_rd;
    logic        res_wr;
    logic [13:0] res_addr;
    logic [7:0]  res_do;
    logic [7:0]  res_di = 8'd0;

    int n_tests = 0;
    int n_fail  = 0;

    res_port_arbiter_if #(.ADDR_W(14), .DATA_W(8)) if_a ();
    res_port_arbiter_if #(.ADDR_W(14), .DATA_W(8)) if_b ();

    res_port_arbiter #(.ADDR_W(14), .DATA_W(8), .MAX_HOLD(MAX_HOLD)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .io_a       (if_a),
        .io_b       (if_b),
        .o_res_rd   (res_rd),
        .o_res_wr   (res_wr),
        .o_res_addr (res_addr),
        .o_res_do   (res_do),
        .i_res_di   (res_di)
    );

    always #5 clk = ~clk;

    // Result RAM: single port, 1-cycle synchronous read.
    logic [7:0] ram     [0:16383];
    logic [7:0] ref_mem [0:16383];
    always @(posedge clk) begin
        if (res_wr) ram[res_addr] <= res_do;
        if (res_rd) res_di <= ram[res_addr];
    end

    // Reference model: owner of last grant (0 none, 1 A, 2 B), last owner,
    // length of current run, and expected read returns per port.
    int         m_owner;
    int         m_last;
    int         m_run;
    logic       m_pend      [1:2];
    logic [7:0] m_pend_data [1:2];

    logic       exp_gnt_a, exp_gnt_b, exp_rd, exp_wr;
    logic [13:0] exp_addr;
    logic [7:0] exp_do;
    logic       exp_rv_a, exp_rv_b;
    logic [7:0] exp_rdata_a, exp_rdata_b;

    task automatic model_reset();
        m_owner = 0;
        m_last  = 2;
        m_run   = 0;
        m_pend[1] = 1'b0;
        m_pend[2] = 1'b0;
        m_pend_data[1] = 8'd0;
        m_pend_data[2] = 8'd0;
    endtask

    task automatic drive_idle();
        if_a.req = 0; if_a.we = 0; if_a.lock = 0; if_a.addr = 0; if_a.wdata = 0;
        if_b.req = 0; if_b.we = 0; if_b.lock = 0; if_b.addr = 0; if_b.wdata = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, settle, then
    // compute what the spec says must be visible before the next rising edge.
    task automatic step(input logic ar, input logic aw, input logic al,
                        input logic [13:0] aa, input logic [7:0] ad,
                        input logic br, input logic bw, input logic bl,
                        input logic [13:0] ba, input logic [7:0] bd);
        int pick, own, oth;
        logic        rq [1:2];
        logic        wq [1:2];
        logic        lk [1:2];
        logic [13:0] ax [1:2];
        logic [7:0]  dx [1:2];
        @(negedge clk);
        if_a.req = ar; if_a.we = aw; if_a.lock = al; if_a.addr = aa; if_a.wdata = ad;
        if_b.req = br; if_b.we = bw; if_b.lock = bl; if_b.addr = ba; if_b.wdata = bd;
        #1;
        rq[1] = ar; wq[1] = aw; lk[1] = al; ax[1] = aa; dx[1] = ad;
        rq[2] = br; wq[2] = bw; lk[2] = bl; ax[2] = ba; dx[2] = bd;

        exp_rv_a    = m_pend[1];
        exp_rv_b    = m_pend[2];
        exp_rdata_a = m_pend[1] ? m_pend_data[1] : 8'd0;
        exp_rdata_b = m_pend[2] ? m_pend_data[2] : 8'd0;

        if (m_owner == 0) begin
            if (rq[1] && rq[2]) pick = 3 - m_last;
            else if (rq[1])     pick = 1;
            else if (rq[2])     pick = 2;
            else                pick = 0;
        end else begin
            own = m_owner;
            oth = 3 - own;
            if (rq[own] && (lk[own] || !rq[oth] || m_run < MAX_HOLD)) pick = own;
            else if (rq[oth]) pick = oth;
            else pick = 0;
        end

        exp_gnt_a = (pick == 1);
        exp_gnt_b = (pick == 2);
        exp_rd    = (pick != 0) && !wq[pick];
        exp_wr    = (pick != 0) &&  wq[pick];
        exp_addr  = (pick != 0) ? ax[pick] : 14'd0;
        exp_do    = (pick != 0) ? dx[pick] : 8'd0;

        m_pend[1] = 1'b0;
        m_pend[2] = 1'b0;
        if (pick != 0) begin
            if (!wq[pick]) begin
                m_pend[pick]      = 1'b1;
                m_pend_data[pick] = ref_mem[ax[pick]];
            end else begin
                ref_mem[ax[pick]] = dx[pick];
            end
            if (pick == m_owner) m_run = (m_run < MAX_HOLD) ? m_run + 1 : MAX_HOLD;
            else                 m_run = 1;
            m_last = pick;
        end else begin
            m_run = 0;
        end
        m_owner = pick;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        if_a.req = 1; if_a.addr = 14'd10;
        if_b.req = 1; if_b.addr = 14'd20;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if ({if_a.gnt, if_b.gnt, if_a.rvalid, if_b.rvalid, res_rd, res_wr} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: gnt_a/gnt_b/rv_a/rv_b/rd/wr=%b required 000000",
                         c, {if_a.gnt, if_b.gnt, if_a.rvalid, if_b.rvalid, res_rd, res_wr});
            end
            n_tests++;
            if (res_addr !== 14'd0 || res_do !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_bus cycle %0d: addr=%0d do=%0d required 0/0", c, res_addr, res_do);
            end
        end
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_read();
        ram[129] = 8'd5;
        ref_mem[129] = 8'd5;
        step(1, 0, 0, 14'd129, 8'd0, 0, 0, 0, 14'd0, 8'd0);
        n_tests++;
        if (if_a.gnt !== 1'b1 || if_b.gnt !== 1'b0 || res_rd !== 1'b1 || res_wr !== 1'b0 || res_addr !== 14'd129) begin
            n_fail++;
            $display("FAIL read_issue: gnt_a=%b gnt_b=%b rd=%b wr=%b addr=%0d required 1 0 1 0 129",
                     if_a.gnt, if_b.gnt, res_rd, res_wr, res_addr);
        end
        step(0, 0, 0, 14'd0, 8'd0, 0, 0, 0, 14'd0, 8'd0);
        n_tests++;
        if (if_a.rvalid !== 1'b1 || if_a.rdata !== 8'd5 || if_b.rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_return: rv_a=%b rdata_a=%0d rv_b=%b required 1 5 0",
                     if_a.rvalid, if_a.rdata, if_b.rvalid);
        end
        n_tests++;
        if (if_a.gnt !== 1'b0 || res_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_grant: gnt_a=%b rd=%b required 0 0", if_a.gnt, res_rd);
        end
        $display("[TB] test_single_read done");
    endtask

    task automatic test_tie();
        do_reset();
        step(1, 0, 0, 14'd1, 8'd0, 1, 0, 0, 14'd2, 8'd0);
        n_tests++;
        if (if_a.gnt !== 1'b1 || if_b.gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_first: gnt_a=%b gnt_b=%b required 1 0", if_a.gnt, if_b.gnt);
        end
        step(0, 0, 0, 14'd0, 8'd0, 0, 0, 0, 14'd0, 8'd0);
        step(1, 0, 0, 14'd3, 8'd0, 1, 0, 0, 14'd4, 8'd0);
        n_tests++;
        if (if_a.gnt !== 1'b0 || if_b.gnt !== 1'b1 || res_addr !== 14'd4) begin
            n_fail++;
            $display("FAIL tie_second: gnt_a=%b gnt_b=%b addr=%0d required 0 1 4",
                     if_a.gnt, if_b.gnt, res_addr);
        end
        $display("[TB] test_tie done");
    endtask

    task automatic test_hold_alternate();
        logic want_a;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 14'(i), 8'd0, 1, 0, 0, 14'(100 + i), 8'd0);
            want_a = ((i / MAX_HOLD) % 2) == 0;
            n_tests++;
            if (if_a.gnt !== want_a || if_b.gnt !== !want_a || res_rd !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_pattern cycle %0d: gnt_a=%b gnt_b=%b rd=%b required %b %b 1",
                         i, if_a.gnt, if_b.gnt, res_rd, want_a, !want_a);
            end
        end
        $display("[TB] test_hold_alternate done");
    endtask

    task automatic test_lock_burst();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) step(1, 0, 1, 14'(100 + i), 8'd0, 1, 0, 0, 14'd200, 8'd0);
            else       step(1, 1, 1, 14'd200, 8'd3, 1, 0, 0, 14'd200, 8'd0);
            n_tests++;
            if (if_a.gnt !== 1'b1 || if_b.gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL burst_grant cycle %0d: gnt_a=%b gnt_b=%b required 1 0", i, if_a.gnt, if_b.gnt);
            end
            if (i > 0) begin
                n_tests++;
                if (if_a.rvalid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL burst_rvalid cycle %0d: rv_a=%b required 1", i, if_a.rvalid);
                end
            end
        end
        step(0, 0, 0, 14'd0, 8'd0, 1, 0, 0, 14'd200, 8'd0);
        n_tests++;
        if (if_b.gnt !== 1'b1 || if_a.gnt !== 1'b0 || res_addr !== 14'd200) begin
            n_fail++;
            $display("FAIL burst_then_b: gnt_a=%b gnt_b=%b addr=%0d required 0 1 200",
                     if_a.gnt, if_b.gnt, res_addr);
        end
        step(0, 0, 0, 14'd0, 8'd0, 0, 0, 0, 14'd0, 8'd0);
        n_tests++;
        if (if_b.rvalid !== 1'b1 || if_b.rdata !== 8'd3 || if_a.rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_readback: rv_b=%b rdata_b=%0d rv_a=%b required 1 3 0",
                     if_b.rvalid, if_b.rdata, if_a.rvalid);
        end
        n_tests++;
        if (ram[200] !== 8'd3) begin
            n_fail++;
            $display("FAIL burst_ram: ram[200]=%0d required 3", ram[200]);
        end
        $display("[TB] test_lock_burst done");
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 14'd55, 8'd0, 0, 0, 0, 14'd0, 8'd0);
        n_tests++;
        if (if_a.gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_grant: gnt_a=%b required 1", if_a.gnt);
        end
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (if_a.rvalid !== 1'b0 || if_a.gnt !== 1'b0 || res_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_rvalid: rv_a=%b gnt_a=%b rd=%b required 0 0 0",
                     if_a.rvalid, if_a.gnt, res_rd);
        end
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        model_reset();
        step(1, 0, 0, 14'd7, 8'd0, 1, 0, 0, 14'd8, 8'd0);
        n_tests++;
        if (if_a.gnt !== 1'b1 || if_b.gnt !== 1'b0 || if_a.rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_tie: gnt_a=%b gnt_b=%b rv_a=%b required 1 0 0",
                     if_a.gnt, if_b.gnt, if_a.rvalid);
        end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_random();
        logic        act [1:2];
        logic        we  [1:2];
        logic        lk  [1:2];
        logic [13:0] ad  [1:2];
        logic [7:0]  wd  [1:2];
        int          errs;
        do_reset();
        for (int p = 1; p <= 2; p++) begin
            act[p] = 0; we[p] = 0; lk[p] = 0; ad[p] = 0; wd[p] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int p = 1; p <= 2; p++) begin
                if (!act[p] && $urandom_range(0, 9) < 7) begin
                    act[p] = 1;
                    we[p]  = $urandom_range(0, 2) == 0;
                    lk[p]  = $urandom_range(0, 5) == 0;
                    ad[p]  = 14'($urandom_range(0, 15));
                    wd[p]  = 8'($urandom);
                end
            end
            step(act[1], we[1], lk[1], ad[1], wd[1], act[2], we[2], lk[2], ad[2], wd[2]);
            errs = 0;
            n_tests++;
            if (if_a.gnt !== exp_gnt_a || if_b.gnt !== exp_gnt_b) begin
                errs++;
                $display("FAIL rand_gnt cycle %0d: gnt_a=%b gnt_b=%b required %b %b",
                         c, if_a.gnt, if_b.gnt, exp_gnt_a, exp_gnt_b);
            end
            n_tests++;
            if (res_rd !== exp_rd || res_wr !== exp_wr || res_addr !== exp_addr || res_do !== exp_do) begin
                errs++;
                $display("FAIL rand_cmd cycle %0d: rd=%b wr=%b addr=%0d do=%0d required %b %b %0d %0d",
                         c, res_rd, res_wr, res_addr, res_do, exp_rd, exp_wr, exp_addr, exp_do);
            end
            n_tests++;
            if (if_a.rvalid !== exp_rv_a || if_a.rdata !== exp_rdata_a) begin
                errs++;
                $display("FAIL rand_ret_a cycle %0d: rv=%b rdata=%0d required %b %0d",
                         c, if_a.rvalid, if_a.rdata, exp_rv_a, exp_rdata_a);
            end
            n_tests++;
            if (if_b.rvalid !== exp_rv_b || if_b.rdata !== exp_rdata_b) begin
                errs++;
                $display("FAIL rand_ret_b cycle %0d: rv=%b rdata=%0d required %b %0d",
                         c, if_b.rvalid, if_b.rdata, exp_rv_b, exp_rdata_b);
            end
            n_fail += errs;
            if (exp_gnt_a) act[1] = 0;
            if (exp_gnt_b) act[2] = 0;
        end
        $display("[TB] test_random done");
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            ram[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        test_reset();
        model_reset();
        test_single_read();
        test_tie();
        test_hold_alternate();
        test_lock_burst();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
